// File: rtl/i2c_cmd_sequencer.sv
// Command-list sequencer: fetches I2C command words from RAM, runs each through the
// I2C master's enable/busy handshake and writes result words back. Optional macro: I2C_RETRY_EN.
module i2c_cmd_sequencer #(
    parameter int MAX_CMDS  = 256,
    parameter int TIMEOUT   = 100000,
    parameter int RETRY_MAX = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    output logic        done,
    output logic        error,
    output logic [8:0]  cmd_count,
    output logic [31:0] ram_addr,
    input  logic [31:0] ram_read,
    output logic [31:0] ram_write,
    output logic [3:0]  ram_byte,
    output logic [6:0]  slave_addr,
    output logic [7:0]  slave_write,
    input  logic [7:0]  slave_read,
    output logic        rw,
    output logic        enable_communication,
    input  logic        busy,
    input  logic        ack_error,
    output logic        i2c_reset_n
);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WAIT_RD,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        WRITEBACK,
        ERR,
        WD_RST,
        WD_WB,
        DONE
    } state_t;

    localparam logic [31:0] RES_OFFSET = 32'(MAX_CMDS * 4);
    localparam int          WD_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t          state;
    state_t          state_next;
    logic [31:0]     base_q;
    logic [8:0]      idx;
    logic            cmd_last;
    logic [7:0]      rd_q;
    logic            nack_q;
    logic [WD_W-1:0] wd_cnt;
    logic [1:0]      rst_cnt;
    logic            wd_expired;
    logic            wd_enter;
    logic            idx_last;
    logic            retry_go;
    logic [31:0]     cmd_addr;
    logic [31:0]     res_addr;

    // Bits [29:16] of a command word are reserved.
    logic unused_cmd_bits;
    assign unused_cmd_bits = ^ram_read[29:16];

    assign cmd_addr   = base_q + {21'b0, idx, 2'b00};
    assign res_addr   = base_q + RES_OFFSET + {21'b0, idx, 2'b00};
    assign idx_last   = (int'(idx) == MAX_CMDS - 1);
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));
    assign wd_enter   = (state_next != state) &&
                        ((state_next == WAIT_HI) || (state_next == WAIT_LO));

`ifdef I2C_RETRY_EN
    localparam int RT_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    logic [RT_W-1:0] retry_cnt;

    assign retry_go = (state == WAIT_LO) && !busy && ack_error &&
                      (int'(retry_cnt) < RETRY_MAX);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            retry_cnt <= '0;
        else if (state == FETCH)
            retry_cnt <= '0;
        else if (retry_go)
            retry_cnt <= retry_cnt + RT_W'(1);
    end
`else
    assign retry_go = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = FETCH;
            FETCH:     state_next = WAIT_RD;
            WAIT_RD:   state_next = ram_read[30] ? ISSUE : DONE;
            ISSUE:     if (!busy) state_next = WAIT_HI;
            WAIT_HI: begin
                if (busy)
                    state_next = WAIT_LO;
                else if (wd_expired)
                    state_next = WD_RST;
            end
            WAIT_LO: begin
                if (!busy)
                    state_next = retry_go ? ISSUE : WRITEBACK;
                else if (wd_expired)
                    state_next = WD_RST;
            end
            WRITEBACK: begin
                if (nack_q)
                    state_next = ERR;
                else if (cmd_last || idx_last)
                    state_next = DONE;
                else
                    state_next = FETCH;
            end
            ERR:       state_next = DONE;
            WD_RST:    if (rst_cnt == 2'd3) state_next = WD_WB;
            WD_WB:     state_next = DONE;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Enable is offered in ISSUE only while the master is idle, and held until busy is seen.
    always_comb begin
        done                 = 1'b0;
        enable_communication = 1'b0;
        ram_addr             = '0;
        ram_write            = '0;
        ram_byte             = '0;
        case (state)
            FETCH:   ram_addr = cmd_addr;
            ISSUE:   enable_communication = !busy;
            WAIT_HI: enable_communication = 1'b1;
            WRITEBACK: begin
                ram_addr  = res_addr;
                ram_write = {23'b0, nack_q, rd_q};
                ram_byte  = 4'b1111;
            end
            WD_WB: begin
                ram_addr  = res_addr;
                ram_write = 32'h0000_0200;
                ram_byte  = 4'b1111;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Watchdog restarts on entry to each busy phase, including retried attempts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            wd_cnt <= '0;
        else if (wd_enter)
            wd_cnt <= '0;
        else if ((state == WAIT_HI) || (state == WAIT_LO))
            wd_cnt <= wd_cnt + WD_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rst_cnt <= '0;
        else if (state == WD_RST)
            rst_cnt <= rst_cnt + 2'd1;
        else
            rst_cnt <= '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_q      <= '0;
            idx         <= '0;
            cmd_count   <= '0;
            error       <= 1'b0;
            slave_addr  <= '0;
            slave_write <= '0;
            rw          <= 1'b0;
            cmd_last    <= 1'b0;
            rd_q        <= '0;
            nack_q      <= 1'b0;
            i2c_reset_n <= 1'b0;
        end else begin
            i2c_reset_n <= (state_next != WD_RST);
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        idx       <= '0;
                        cmd_count <= '0;
                        error     <= 1'b0;
                    end
                end
                WAIT_RD: begin
                    // Slave fields stay frozen from here until the next valid command.
                    if (ram_read[30]) begin
                        slave_addr  <= ram_read[6:0];
                        rw          <= ram_read[7];
                        slave_write <= ram_read[15:8];
                        cmd_last    <= ram_read[31];
                    end
                end
                WAIT_LO: begin
                    if (!busy) begin
                        rd_q   <= slave_read;
                        nack_q <= ack_error;
                    end
                end
                WRITEBACK: begin
                    cmd_count <= cmd_count + 9'd1;
                    if (state_next == FETCH)
                        idx <= idx + 9'd1;
                end
                ERR, WD_WB: error <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Scoreboard bench for i2c_cmd_sequencer: RAM and I2C master models, queued expectations
// checked by an independent monitor on every transaction, RAM write and done pulse.
module tb_i2c_cmd_sequencer;

    localparam int TIMEOUT = 16;

    typedef struct packed { logic [6:0] addr; logic rw; logic [7:0] data; } txn_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct packed { logic [8:0] count; logic err; } done_t;
    typedef struct packed { logic nack; logic [7:0] data; } resp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        done;
    logic        error;
    logic [8:0]  cmd_count;
    logic [31:0] ram_addr;
    logic [31:0] ram_read;
    logic [31:0] ram_write;
    logic [3:0]  ram_byte;
    logic [6:0]  slave_addr;
    logic [7:0]  slave_write;
    logic [7:0]  slave_read = '0;
    logic        rw;
    logic        enable_communication;
    logic        busy = 1'b0;
    logic        ack_error = 1'b0;
    logic        i2c_reset_n;

    always #5 clk = ~clk;

    i2c_cmd_sequencer #(.MAX_CMDS(256), .TIMEOUT(TIMEOUT), .RETRY_MAX(3)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .done(done), .error(error), .cmd_count(cmd_count),
        .ram_addr(ram_addr), .ram_read(ram_read), .ram_write(ram_write), .ram_byte(ram_byte),
        .slave_addr(slave_addr), .slave_write(slave_write), .slave_read(slave_read),
        .rw(rw), .enable_communication(enable_communication), .busy(busy),
        .ack_error(ack_error), .i2c_reset_n(i2c_reset_n)
    );

    // RAM model: one-cycle read latency, loader port used only while the DUT is idle.
    logic [31:0] mem [0:4095];
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;

    always @(posedge clk) begin
        ram_read <= mem[ram_addr[13:2]];
        if (ld_en)
            mem[ld_addr[13:2]] <= ld_data;
        else if (ram_byte != 4'b0)
            mem[ram_addr[13:2]] <= ram_write;
    end

    txn_t  exp_txn[$];
    wr_t   exp_wr[$];
    done_t exp_done[$];
    resp_t slv_resp[$];

    int n_tests = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, want);
        end
    endtask

    task automatic fail_now(input string name, input string info);
        n_tests++;
        n_fail++;
        $display("FAIL %s: %s", name, info);
    endtask

    // I2C master model: busy rises the cycle after enable is taken, stays high busy_len edges.
    bit slave_hang = 1'b0;
    int busy_len = 2;

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && enable_communication && !slave_hang && !busy) begin
                resp_t r;
                if (slv_resp.size() > 0)
                    r = slv_resp.pop_front();
                else
                    r = '0;
                @(posedge clk);
                #1 busy = 1'b1;
                repeat (busy_len) @(posedge clk);
                #1;
                slave_read = r.data;
                ack_error  = r.nack;
                busy       = 1'b0;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a transaction, write or done.
    txn_t        cur_txn = '0;
    bit          in_txn = 1'b0;
    logic        en_q = 1'b0;
    logic        busy_q = 1'b0;
    int          wr_cnt = 0;
    int          rst_low_cnt = 0;
    bit          watch_hit = 1'b0;
    logic [31:0] watch_addr = '1;

    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                in_txn = 1'b0;
            end else begin
                if (enable_communication && !en_q) begin
                    if (exp_txn.size() == 0) begin
                        fail_now("unexpected_txn", $sformatf("got slave_addr 0x%0h, required no transaction", slave_addr));
                    end else begin
                        cur_txn = exp_txn.pop_front();
                        in_txn  = 1'b1;
                        check("txn_fields", {slave_addr, rw, slave_write}, cur_txn);
                    end
                end
                if (!busy && busy_q && in_txn) begin
                    check("txn_held", {slave_addr, rw, slave_write}, cur_txn);
                    in_txn = 1'b0;
                end
                if (ram_byte != 4'b0) begin
                    wr_cnt++;
                    if (exp_wr.size() == 0) begin
                        fail_now("unexpected_write", $sformatf("got addr 0x%0h data 0x%0h, required no write", ram_addr, ram_write));
                    end else begin
                        wr_t w;
                        w = exp_wr.pop_front();
                        check("wr_addr", ram_addr, w.addr);
                        check("wr_data", ram_write, w.data);
                        check("wr_strobe", ram_byte, 4'b1111);
                    end
                end
                if (done) begin
                    in_txn = 1'b0;
                    if (exp_done.size() == 0) begin
                        fail_now("unexpected_done", $sformatf("got cmd_count %0d, required no done", cmd_count));
                    end else begin
                        done_t d;
                        d = exp_done.pop_front();
                        check("done_count_error", {cmd_count, error}, d);
                    end
                end
                if (!i2c_reset_n) begin
                    rst_low_cnt++;
                    check("enable_low_in_wd_reset", enable_communication, 1'b0);
                end
                if (ram_byte == 4'b0 && ram_addr == watch_addr)
                    watch_hit = 1'b1;
            end
            en_q   = enable_communication;
            busy_q = busy;
        end
    end

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic push_txn(input logic [6:0] a, input logic r, input logic [7:0] d);
        txn_t t;
        t = {a, r, d};
        exp_txn.push_back(t);
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        wr_t w;
        w = {a, d};
        exp_wr.push_back(w);
    endtask

    task automatic push_done(input logic [8:0] c, input logic e);
        done_t d;
        d = {c, e};
        exp_done.push_back(d);
    endtask

    task automatic push_resp(input logic n, input logic [7:0] d);
        resp_t r;
        r = {n, d};
        slv_resp.push_back(r);
    endtask

    task automatic pulse_start(input logic [31:0] base);
        @(negedge clk);
        base_addr = base;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Cycles counted from the negedge on which start was raised.
    task automatic expect_latency(input string name, input int want, input bit on_done);
        int lat = 1;
        while (!(on_done ? done : enable_communication) && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check(name, lat, want);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done)
            fail_now(name, $sformatf("no done within %0d cycles", budget));
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int    n;
        int    wr_snap;

        repeat (3) @(negedge clk);
        check("rst_ctrl", {done, error, cmd_count, enable_communication, rw, i2c_reset_n, ram_byte}, '0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_write", ram_write, 32'h0);
        check("rst_slave", {slave_addr, slave_write}, '0);
        reset_n = 1'b1;
        @(negedge clk);
        check("i2c_reset_release", i2c_reset_n, 1'b1);

        // Three ACKed writes, last flag on the third.
        load(32'h100, 32'h4000_1121);
        load(32'h104, 32'h4000_5A22);
        load(32'h108, 32'hC000_C323);
        push_txn(7'h21, 1'b0, 8'h11);
        push_txn(7'h22, 1'b0, 8'h5A);
        push_txn(7'h23, 1'b0, 8'hC3);
        for (int i = 0; i < 3; i++) push_resp(1'b0, 8'h00);
        push_wr(32'h500, 32'h0);
        push_wr(32'h504, 32'h0);
        push_wr(32'h508, 32'h0);
        push_done(9'd3, 1'b0);
        pulse_start(32'h100);
        expect_latency("start_to_enable", 3, 1'b0);
        wait_done("done_writes", 200);
        repeat (3) @(negedge clk);
        check("cmd_count_held", cmd_count, 9'd3);

        // Single read from slave 0x50 returning 0xA5.
        load(32'h200, 32'hC000_00D0);
        push_txn(7'h50, 1'b1, 8'h00);
        push_resp(1'b0, 8'hA5);
        push_wr(32'h600, 32'h0000_00A5);
        push_done(9'd1, 1'b0);
        pulse_start(32'h200);
        wait_done("done_read", 100);

        // Second command NACKs.
        load(32'h300, 32'h4000_0110);
        load(32'h304, 32'h4000_0211);
        load(32'h308, 32'hC000_0312);
        watch_hit  = 1'b0;
        watch_addr = 32'h308;
        push_txn(7'h10, 1'b0, 8'h01);
        push_resp(1'b0, 8'h00);
        push_wr(32'h700, 32'h0);
`ifdef I2C_RETRY_EN
        for (int i = 0; i < 3; i++) push_txn(7'h11, 1'b0, 8'h02);
        push_resp(1'b1, 8'h00);
        push_resp(1'b1, 8'h00);
        push_resp(1'b0, 8'h00);
        push_wr(32'h704, 32'h0);
        push_txn(7'h12, 1'b0, 8'h03);
        push_resp(1'b0, 8'h00);
        push_wr(32'h708, 32'h0);
        push_done(9'd3, 1'b0);
        pulse_start(32'h300);
        wait_done("done_retry", 300);
`else
        push_txn(7'h11, 1'b0, 8'h02);
        push_resp(1'b1, 8'h00);
        push_wr(32'h704, 32'h0000_0100);
        push_done(9'd2, 1'b1);
        pulse_start(32'h300);
        wait_done("done_nack", 200);
        check("cmd3_not_fetched", watch_hit, 1'b0);
`endif
        watch_addr = '1;

        // Master never raises busy: watchdog abort.
        slave_hang  = 1'b1;
        rst_low_cnt = 0;
        load(32'h1000, 32'hC000_4433);
        push_txn(7'h33, 1'b0, 8'h44);
        push_wr(32'h1400, 32'h0000_0200);
        push_done(9'd0, 1'b1);
        pulse_start(32'h1000);
        wait_done("done_timeout", 100);
        check("wd_reset_cycles", rst_low_cnt, 4);
        slave_hang = 1'b0;

        // Word 0 invalid: immediate done, error cleared by the accepted start.
        load(32'h2000, 32'h0000_0000);
        push_done(9'd0, 1'b0);
        pulse_start(32'h2000);
        expect_latency("start_to_done_invalid", 3, 1'b1);
        wait_done("done_invalid", 20);

        // Reset asserted while waiting for busy to fall.
        busy_len = 10;
        load(32'h3000, 32'hC000_7755);
        push_txn(7'h55, 1'b0, 8'h77);
        push_resp(1'b0, 8'h99);
        wr_snap = wr_cnt;
        pulse_start(32'h3000);
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("busy_seen", busy, 1'b1);
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_ctrl", {done, error, cmd_count, enable_communication, rw, i2c_reset_n, ram_byte}, '0);
        check("async_rst_ram_addr", ram_addr, 32'h0);
        check("async_rst_ram_write", ram_write, 32'h0);
        check("async_rst_slave", {slave_addr, slave_write}, '0);
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("i2c_reset_release2", i2c_reset_n, 1'b1);
        check("no_write_on_reset", wr_cnt, wr_snap);
        busy_len = 2;

        // Fresh batch after the abort.
        load(32'h3100, 32'hC000_2AD0);
        push_txn(7'h50, 1'b1, 8'h2A);
        push_resp(1'b0, 8'h3C);
        push_wr(32'h3500, 32'h0000_003C);
        push_done(9'd1, 1'b0);
        pulse_start(32'h3100);
        wait_done("done_after_reset", 100);

        repeat (3) @(negedge clk);
        check("txn_queue_drained", exp_txn.size(), 0);
        check("wr_queue_drained", exp_wr.size(), 0);
        check("done_queue_drained", exp_done.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
